f1_light_sequencer: RTL and testbench
=====================================

// Module: f1_light_sequencer
// PURPOSE
//  Top-level sequencer for the F1 start-lights / reaction-timer datapath.
//  - Steps N_LIGHTS lamps on, one per external tick.
//  - Loads a pseudo-random hold time into the external one-shot delay block (K/trigger/time_out) and fires it.
//  - Blanks the lights on time_out, then measures clk cycles until the driver presses react.
// PARAMETERS
//  WIDTH     7   delay-count width; dly_k width. LFSR taps are defined for 7 only; other values illegal.
//  N_LIGHTS  8   number of start lamps
//  K_MIN     4   minimum delay loaded; LFSR values below this are clamped up to K_MIN
//  CNT_W     16  reaction counter width
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  rst_n         in   1         asynchronous, active-low reset
//  start         in   1         begin sequence; sampled only in IDLE
//  tick          in   1         1-cycle step pulse from the clock divider
//  time_out      in   1         one-cycle pulse from the delay block
//  react         in   1         driver button, synchronous, level
//  lights        out  N_LIGHTS  lamp drive; bit 0 lights first
//  dly_k         out  WIDTH     delay length to delay block
//  dly_trigger   out  1         start pulse to delay block
//  busy          out  1         high in every state except IDLE
//  react_cycles  out  CNT_W     last measured reaction time
//  react_valid   out  1         1-cycle pulse when react_cycles updates
//  false_start   out  1         1-cycle abort pulse (FALSE_START_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, FSM=IDLE, LFSR=7'h01, react counter=0.
//  - All outputs are registered (Moore); no combinational input->output path.
//  - LFSR: free-running every clk in all states: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[2]}.
//    - Never 0; period 127.
//  - States:
//    IDLE -> LIGHTS_ON     when start=1.
//    LIGHTS_ON             per tick: lights <= {lights[N-2:0],1'b1}.
//                          tick while lights all-ones -> ARM; lights stay all-ones.
//    ARM                   exactly 1 cycle.
//                          On entry, dly_k <= (lfsr<K_MIN ? K_MIN : lfsr); dly_k holds until the next ARM.
//                          dly_trigger=1 only during ARM. Next state WAIT_DELAY.
//    WAIT_DELAY            hold lights; time_out=1 -> LIGHTS_OUT, lights <= 0, cnt <= 0.
//    LIGHTS_OUT            react=0: cnt <= cnt+1, saturating at all-ones (no wrap).
//                          react=1: react_cycles <= cnt, react_valid=1 for 1 cycle, -> IDLE.
//  - Latency: react high on the first LIGHTS_OUT cycle gives react_cycles=0.
//  - start while busy: ignored. tick outside LIGHTS_ON: ignored.
//  - time_out outside WAIT_DELAY: ignored.
//  - react outside LIGHTS_OUT: ignored unless FALSE_START_EN.
//  - react_cycles holds its value until the next valid measurement; unchanged on abort.
//  - Reset mid-sequence: immediate return to reset values; dly_trigger drops asynchronously.
// CONFIGURATION
//  FALSE_START_EN defined:
//    - react=1 in LIGHTS_ON, ARM or WAIT_DELAY aborts to IDLE next cycle.
//    - Abort drives lights <= 0 and pulses false_start for 1 cycle.
//    - react_valid stays 0 on abort.
//    - Abort in ARM still issues that cycle's dly_trigger; a later time_out is ignored in IDLE.
//  FALSE_START_EN undefined: false_start tied 0; react is ignored outside LIGHTS_OUT.
// TESTING
//  1. rst_n=0 mid-WAIT_DELAY -> same cycle lights=0, busy=0, dly_trigger=0; after release LFSR restarts at 7'h01.
//  2. start, 8 ticks -> lights 01,03,..,FF; 9th tick -> single-cycle dly_trigger with dly_k=clamped LFSR, lights=FF.
//  3. time_out pulse, react after 37 cycles -> lights=00; react_cycles=37, react_valid 1 cycle; busy=0 next cycle.
//  4. Force LFSR=7'h02 at ARM with K_MIN=4 -> dly_k=4; LFSR=7'h50 -> dly_k=7'h50.
//  5. React held off 70000 cycles with CNT_W=16 -> react_cycles=16'hFFFF (saturates, no wrap).
//  6. FALSE_START_EN, react during lights=07 -> false_start pulse, lights=00, IDLE; react_cycles unchanged.

Source files
------------

// File: rtl/f1_light_sequencer_if.sv
// f1_light_sequencer_if: control/status bundle between the start-light sequencer and its environment.
interface f1_light_sequencer_if #(
  parameter int WIDTH    = 7,
  parameter int N_LIGHTS = 8,
  parameter int CNT_W    = 16
);
  logic                start, tick, time_out, react;
  logic [N_LIGHTS-1:0] lights;
  logic [WIDTH-1:0]    dly_k;
  logic                dly_trigger, busy;
  logic [CNT_W-1:0]    react_cycles;
  logic                react_valid, false_start;
  modport slave (
    input  start, tick, time_out, react,
    output lights, dly_k, dly_trigger, busy, react_cycles, react_valid, false_start
  );
  modport master (
    output start, tick, time_out, react,
    input  lights, dly_k, dly_trigger, busy, react_cycles, react_valid, false_start
  );
endinterface

// File: rtl/f1_light_sequencer.sv
// f1_light_sequencer: F1 start-light stepper, random hold-time launcher and reaction timer.
// Optional macro FALSE_START_EN enables the react-before-lights-out abort.
module f1_light_sequencer #(
  parameter int WIDTH    = 7,
  parameter int N_LIGHTS = 8,
  parameter int K_MIN    = 4,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  f1_light_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LIGHTS_ON, ARM, WAIT_DELAY, LIGHTS_OUT} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lfsr_q, dly_k_q, dly_k_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, rc_q, rc_d;
  logic                valid_q, valid_d, fs_q, fs_d, abort;
`ifdef FALSE_START_EN
  assign abort = bus.react && (state_q inside {LIGHTS_ON, ARM, WAIT_DELAY});
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    dly_k_d  = dly_k_q;
    cnt_d    = cnt_q;
    rc_d     = rc_q;
    valid_d  = 1'b0;
    fs_d     = abort;
    case (state_q)
      IDLE:       if (bus.start) state_d = LIGHTS_ON;
      LIGHTS_ON:  if (bus.tick) begin
        if (&lights_q) begin
          state_d = ARM;
          dly_k_d = (lfsr_q < WIDTH'(K_MIN)) ? WIDTH'(K_MIN) : lfsr_q;
        end else
          lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
      end
      ARM:        state_d = WAIT_DELAY;
      WAIT_DELAY: if (bus.time_out) begin
        state_d  = LIGHTS_OUT;
        lights_d = '0;
        cnt_d    = '0;
      end
      LIGHTS_OUT: if (bus.react) begin
        state_d = IDLE;
        rc_d    = cnt_q;
        valid_d = 1'b1;
      end else
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      default:    state_d = IDLE;
    endcase
    // an abort overrides any tick/time_out seen in the same cycle
    if (abort) begin
      state_d  = IDLE;
      lights_d = '0;
      dly_k_d  = dly_k_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= WIDTH'(1);
      lights_q <= '0;
      dly_k_q  <= '0;
      cnt_q    <= '0;
      rc_q     <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= {lfsr_q[WIDTH-2:0], lfsr_q[6] ^ lfsr_q[2]};
      lights_q <= lights_d;
      dly_k_q  <= dly_k_d;
      cnt_q    <= cnt_d;
      rc_q     <= rc_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
    end
  assign bus.lights       = lights_q;
  assign bus.dly_k        = dly_k_q;
  assign bus.dly_trigger  = state_q == ARM;
  assign bus.busy         = state_q != IDLE;
  assign bus.react_cycles = rc_q;
  assign bus.react_valid  = valid_q;
  assign bus.false_start  = fs_q;
endmodule

// File: tb/tb_f1_light_sequencer.sv
// tb_f1_light_sequencer: randomized self-checking bench against a cycle-indexed LFSR table and lamp-count model.
module tb_f1_light_sequencer;
  localparam int N = 8, W = 7, KMIN = 4, CW = 16;
`ifdef FALSE_START_EN
  localparam bit FSE = 1'b1;
`else
  localparam bit FSE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  f1_light_sequencer_if #(.WIDTH(W), .N_LIGHTS(N), .CNT_W(CW)) bus ();
  f1_light_sequencer #(.WIDTH(W), .N_LIGHTS(N), .K_MIN(KMIN), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, ncyc, lit = 0;
  int seq [127];
  logic [CW-1:0] exp_rc = '0;
  logic [W-1:0]  k;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else ncyc <= ncyc + 1;
  function automatic logic [N-1:0] lmask(input int n);
    return N'((1 << n) - 1);
  endfunction
  function automatic int clamp(input int v);
    return v < KMIN ? KMIN : v;
  endfunction
  task automatic idle_inputs;
    bus.start = 1'b0; bus.tick = 1'b0; bus.time_out = 1'b0; bus.react = 1'b0;
  endtask
  task automatic do_start;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", bus.busy); end
    idle_inputs();
    bus.start = 1'b1;
    lit = 0;
  endtask
  task automatic do_ticks(input int upto);
    while (lit < upto) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checks++; if ({bus.busy, bus.lights} !== {1'b1, lmask(lit)}) begin errors++; $display("FAIL lights_hold: got %b/%h exp 1/%h", bus.busy, bus.lights, lmask(lit)); end
        bus.tick = 1'b0; bus.start = 1'($urandom); bus.time_out = 1'($urandom);
        bus.react = FSE ? 1'b0 : 1'($urandom);
      end
      @(negedge clk);
      checks++; if ({bus.busy, bus.lights} !== {1'b1, lmask(lit)}) begin errors++; $display("FAIL lights_step: got %b/%h exp 1/%h", bus.busy, bus.lights, lmask(lit)); end
      idle_inputs();
      bus.tick = 1'b1;
      lit++;
    end
  endtask
  task automatic do_arm(input int target, output logic [W-1:0] kk);
    int i = 0;
    @(negedge clk);
    checks++; if (bus.lights !== lmask(N)) begin errors++; $display("FAIL lights_full: got %h exp %h", bus.lights, lmask(N)); end
    idle_inputs();
    while (target >= 0 && seq[ncyc % 127] != target && i < 130) begin
      @(negedge clk);
      i++;
    end
    if (target >= 0 && seq[ncyc % 127] != target) begin
      checks++; errors++; $display("FAIL lfsr_target: got %h exp %h", seq[ncyc % 127], target);
    end
    kk = W'(clamp(seq[ncyc % 127]));
    bus.tick = 1'b1;
    @(negedge clk);
    checks++; if ({bus.dly_trigger, bus.busy, bus.lights} !== {2'b11, lmask(N)}) begin errors++; $display("FAIL arm_state: got trig=%b busy=%b lights=%h exp 1/1/%h", bus.dly_trigger, bus.busy, bus.lights, lmask(N)); end
    checks++; if (bus.dly_k !== kk) begin errors++; $display("FAIL arm_dly_k: got %h exp %h", bus.dly_k, kk); end
    bus.tick = 1'b0;
  endtask
  task automatic do_wait_react(input int d);
    int w = $urandom_range(1, 5);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      checks++; if ({bus.dly_trigger, bus.busy, bus.lights} !== {2'b01, lmask(N)}) begin errors++; $display("FAIL wait_state: got trig=%b busy=%b lights=%h exp 0/1/%h", bus.dly_trigger, bus.busy, bus.lights, lmask(N)); end
      bus.start = 1'($urandom); bus.tick = 1'($urandom);
      bus.react = FSE ? 1'b0 : 1'($urandom);
      bus.time_out = (i == w - 1);
    end
    for (int j = 0; j <= d; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checks++; if ({bus.busy, bus.react_valid, bus.lights} !== {2'b10, lmask(0)}) begin errors++; $display("FAIL lights_out: got busy=%b valid=%b lights=%h exp 1/0/00", bus.busy, bus.react_valid, bus.lights); end
      end
      bus.tick = 1'($urandom); bus.time_out = 1'($urandom);
      bus.start = (j == d) ? 1'b0 : 1'($urandom);
      bus.react = (j == d);
    end
    exp_rc = (d > 65535) ? CW'(65535) : CW'(d);
    @(negedge clk);
    checks++; if ({bus.react_valid, bus.busy} !== 2'b10) begin errors++; $display("FAIL react_pulse: got valid=%b busy=%b exp 1/0", bus.react_valid, bus.busy); end
    checks++; if (bus.react_cycles !== exp_rc) begin errors++; $display("FAIL react_cycles: got %0d exp %0d", bus.react_cycles, exp_rc); end
    idle_inputs();
    @(negedge clk);
    checks++; if ({bus.react_valid, bus.busy, bus.react_cycles} !== {2'b00, exp_rc}) begin errors++; $display("FAIL react_after: got valid=%b busy=%b rc=%0d exp 0/0/%0d", bus.react_valid, bus.busy, bus.react_cycles, exp_rc); end
  endtask
  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.lights, bus.dly_k, bus.dly_trigger, bus.busy, bus.react_cycles, bus.react_valid, bus.false_start} !== '0) begin errors++; $display("FAIL reset_outputs: got lights=%h k=%h trig=%b busy=%b rc=%h valid=%b fs=%b exp all 0", bus.lights, bus.dly_k, bus.dly_trigger, bus.busy, bus.react_cycles, bus.react_valid, bus.false_start); end
    rst_n = 1'b1;
  endtask
  task automatic test_sequence;
    for (int n = 0; n < 6; n++) begin
      do_start(); do_ticks(N); do_arm(-1, k); do_wait_react($urandom_range(0, 60));
    end
    do_start(); do_ticks(N); do_arm(-1, k); do_wait_react(37);
  endtask
  task automatic test_clamp;
    int tg [4] = '{2, 'h50, 1, 3};
    for (int n = 0; n < 4; n++) begin
      do_start(); do_ticks(N); do_arm(tg[n], k);
      checks++; if (bus.dly_k !== W'(clamp(tg[n]))) begin errors++; $display("FAIL clamp_k: got %h exp %h", bus.dly_k, clamp(tg[n])); end
      do_wait_react($urandom_range(0, 10));
    end
  endtask
  task automatic test_reset_mid;
    do_start(); do_ticks(N); do_arm(-1, k);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.lights, bus.busy, bus.dly_trigger, bus.dly_k, bus.react_cycles, bus.react_valid} !== '0) begin errors++; $display("FAIL reset_mid: got lights=%h busy=%b trig=%b k=%h rc=%h valid=%b exp all 0", bus.lights, bus.busy, bus.dly_trigger, bus.dly_k, bus.react_cycles, bus.react_valid); end
    exp_rc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(); do_ticks(N); do_arm(-1, k); do_wait_react($urandom_range(0, 20));
  endtask
  task automatic test_saturation;
    do_start(); do_ticks(N); do_arm(-1, k); do_wait_react(70000);
  endtask
`ifdef FALSE_START_EN
  task automatic test_false_start;
    logic [CW-1:0] rc0 = exp_rc;
    do_start(); do_ticks(3);
    @(negedge clk);
    checks++; if (bus.lights !== 8'h07) begin errors++; $display("FAIL fs_pre_lights: got %h exp 07", bus.lights); end
    idle_inputs(); bus.react = 1'b1;
    @(negedge clk);
    checks++; if ({bus.false_start, bus.busy, bus.react_valid, bus.lights} !== {3'b100, 8'h00}) begin errors++; $display("FAIL fs_abort: got fs=%b busy=%b valid=%b lights=%h exp 1/0/0/00", bus.false_start, bus.busy, bus.react_valid, bus.lights); end
    checks++; if (bus.react_cycles !== rc0) begin errors++; $display("FAIL fs_rc_hold: got %0d exp %0d", bus.react_cycles, rc0); end
    bus.react = 1'b0;
    @(negedge clk);
    checks++; if ({bus.false_start, bus.busy} !== 2'b00) begin errors++; $display("FAIL fs_pulse_end: got fs=%b busy=%b exp 0/0", bus.false_start, bus.busy); end
    do_start(); do_ticks(N); do_arm(-1, k);
    bus.react = 1'b1;
    @(negedge clk);
    checks++; if ({bus.false_start, bus.busy, bus.lights, bus.dly_k} !== {2'b10, 8'h00, k}) begin errors++; $display("FAIL fs_arm_abort: got fs=%b busy=%b lights=%h k=%h exp 1/0/00/%h", bus.false_start, bus.busy, bus.lights, bus.dly_k, k); end
    idle_inputs(); bus.time_out = 1'b1;
    @(negedge clk);
    bus.time_out = 1'b0;
    @(negedge clk);
    checks++; if ({bus.false_start, bus.busy, bus.lights, bus.react_valid} !== {2'b00, 8'h00, 1'b0}) begin errors++; $display("FAIL fs_timeout_ignored: got fs=%b busy=%b lights=%h valid=%b exp 0/0/00/0", bus.false_start, bus.busy, bus.lights, bus.react_valid); end
  endtask
`else
  task automatic test_react_ignored;
    do_start(); do_ticks(3);
    @(negedge clk);
    idle_inputs(); bus.react = 1'b1;
    @(negedge clk);
    checks++; if ({bus.false_start, bus.busy, bus.lights} !== {2'b01, 8'h07}) begin errors++; $display("FAIL react_ignored: got fs=%b busy=%b lights=%h exp 0/1/07", bus.false_start, bus.busy, bus.lights); end
    bus.react = 1'b0;
    do_ticks(N); do_arm(-1, k); do_wait_react($urandom_range(0, 15));
  endtask
`endif
  initial begin
    seq[0] = 1;
    for (int i = 1; i < 127; i++) seq[i] = ((seq[i-1] << 1) & 127) | (((seq[i-1] >> 6) ^ (seq[i-1] >> 2)) & 1);
    test_reset();
    test_sequence();
    test_clamp();
    test_reset_mid();
`ifdef FALSE_START_EN
    test_false_start();
`else
    test_react_ignored();
`endif
    test_saturation();
    do_start(); do_ticks(N); do_arm(-1, k); do_wait_react(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
